// File: rtl/arb_requester_pkg.sv
// Shared constants for the priority-arbiter requester agent.
package arb_requester_pkg;

  // Default geometry of a requester instance.
  localparam int unsigned ARB_NUM_PORTS = 4;
  localparam int unsigned ARB_CNT_W     = 3;

  // Width of a binary index that can address n ports (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// One-hot to binary encoder with one-hot and all-zero qualifiers.
module arb_onehot_enc
  import arb_requester_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = ARB_NUM_PORTS,
  localparam int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] vec_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 onehot_o,
  output logic                 zero_o
);

  // Encode by OR-ing the indices of all set bits; exact when the input is one-hot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (vec_i[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign zero_o   = (vec_i == '0);
  assign onehot_o = !zero_o && ((vec_i & (vec_i - NUM_PORTS'(1))) == '0);

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for a one-hot priority arbiter: per-port pending
// counters drive the request vector, returned grants are checked, consumed
// and reported as a binary index.
module arb_requester
  import arb_requester_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = ARB_NUM_PORTS,
  parameter  int unsigned CNT_W     = ARB_CNT_W,
  localparam int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] push_i,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic                 grant_valid_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic [NUM_PORTS-1:0] full_o,
  output logic [NUM_PORTS-1:0] drop_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_onehot;
  logic                 gnt_zero;
  logic                 gnt_legal;
  logic                 gnt_illegal;
  logic [NUM_PORTS-1:0] drop_d;

  arb_onehot_enc #(
    .NUM_PORTS (NUM_PORTS)
  ) u_enc (
    .vec_i    (gnt_i),
    .idx_o    (gnt_idx),
    .onehot_o (gnt_onehot),
    .zero_o   (gnt_zero)
  );

  // A grant is only honoured if it is one-hot and lands on a port that is requesting.
  assign gnt_legal   = gnt_onehot && ((gnt_i & req_o) != '0);
  assign gnt_illegal = !gnt_zero && !gnt_legal;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CNT_W-1:0] cnt_q;
    logic             granted;
    logic             full;

    assign granted   = gnt_legal && gnt_i[i];
    assign full      = (cnt_q == CNT_MAX);
    // req/full come from the counter alone, keeping the arbiter loop acyclic.
    assign req_o[i]  = (cnt_q != '0);
    assign full_o[i] = full;
    // A push meeting a grant on the same port nets to zero and is never dropped.
    assign drop_d[i] = push_i[i] && !granted && full;

    // Pending-request counter: decrement on grant, increment on push, saturate at max.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (granted && !push_i[i]) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (push_i[i] && !granted && !full) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Grant report: one-cycle valid pulse; the index holds between grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_valid_o <= 1'b0;
      grant_idx_o   <= '0;
    end else begin
      grant_valid_o <= gnt_legal;
      if (gnt_legal) grant_idx_o <= gnt_idx;
    end
  end

  // Drop pulses mirror this cycle's discarded pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_o <= '0;
    else        drop_o <= drop_d;
  end

  // Sticky protocol error; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           err_o <= 1'b0;
    else if (gnt_illegal) err_o <= 1'b1;
    else if (err_clr_i)   err_o <= 1'b0;
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed and scoreboard-checked bench for arb_requester (4 ports, 3-bit counters).
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] push_i = '0;
  logic [3:0] req_o;
  logic [3:0] gnt_i = '0;
  logic       grant_valid_o;
  logic [1:0] grant_idx_o;
  logic [3:0] full_o;
  logic [3:0] drop_o;
  logic       err_o;
  logic       err_clr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  arb_requester #(.NUM_PORTS(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .grant_valid_o (grant_valid_o),
    .grant_idx_o   (grant_idx_o),
    .full_o        (full_o),
    .drop_o        (drop_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference fixed-priority arbiter: lowest-numbered requester wins.
  function automatic logic [3:0] prio(input logic [3:0] req);
    for (int i = 0; i < 4; i++) if (req[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0100, 4'b0100, 4'b0100};
  logic [1:0] exp_idx [4] = '{2'd0, 2'd2, 2'd2, 2'd2};

  int         m_cnt [4];
  logic [3:0] m_req, m_full, m_drop;
  logic       m_gv;
  logic [1:0] m_idx;
  logic [3:0] r_push, r_gnt;
  int         rnd_bad_start;

  initial begin
    // Reset state
    #2;
    check("rst_req",  req_o, 4'b0000);
    check("rst_full", full_o, 4'b0000);
    check("rst_gv",   grant_valid_o, 1'b0);
    check("rst_idx",  grant_idx_o, 2'd0);
    check("rst_drop", drop_o, 4'b0000);
    check("rst_err",  err_o, 1'b0);
    #5 reset = 1'b1;

    // Idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_req", req_o, 4'b0000);
      check("idle_err", err_o, 1'b0);
      check("idle_gv",  grant_valid_o, 1'b0);
    end

    // Port 2 x3, port 0 x1, then drain through the priority arbiter
    push_i = 4'b0101; step();
    push_i = 4'b0100; step(); step();
    push_i = 4'b0000;
    check("load_req",  req_o, 4'b0101);
    check("load_full", full_o, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      gnt_i = prio(req_o);
      check("arb_gnt", gnt_i, exp_gnt[k]);
      step();
      check("arb_gv",  grant_valid_o, 1'b1);
      check("arb_idx", grant_idx_o, exp_idx[k]);
    end
    gnt_i = 4'b0000;
    check("drain_req", req_o, 4'b0000);
    step();
    check("drain_gv",   grant_valid_o, 1'b0);
    check("idx_hold",   grant_idx_o, 2'd2);
    check("drain_err",  err_o, 1'b0);

    // Saturation on port 1
    push_i = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      step();
      check("sat_nodrop", drop_o, 4'b0000);
    end
    check("sat_full", full_o, 4'b0010);
    check("sat_req",  req_o, 4'b0010);
    step();
    check("sat_drop8", drop_o, 4'b0010);
    check("sat_full8", full_o, 4'b0010);
    push_i = 4'b0000; step();
    check("sat_dropclr", drop_o, 4'b0000);
    push_i = 4'b0010; gnt_i = 4'b0010; step();
    check("pg_drop", drop_o, 4'b0000);
    check("pg_full", full_o, 4'b0010);
    check("pg_gv",   grant_valid_o, 1'b1);
    check("pg_idx",  grant_idx_o, 2'd1);
    push_i = 4'b0000; gnt_i = 4'b0000; step();
    check("pg_gv0",  grant_valid_o, 1'b0);
    check("pg_full2", full_o, 4'b0010);

    // Illegal grants
    push_i = 4'b0100; step(); push_i = 4'b0000;
    check("ill_req0", req_o, 4'b0110);
    gnt_i = 4'b0110; step(); gnt_i = 4'b0000;
    check("ill_err",  err_o, 1'b1);
    check("ill_gv",   grant_valid_o, 1'b0);
    check("ill_req",  req_o, 4'b0110);
    check("ill_full", full_o, 4'b0010);
    step();
    check("ill_sticky", err_o, 1'b1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    check("ill_clr", err_o, 1'b0);
    gnt_i = 4'b1000; step(); gnt_i = 4'b0000;
    check("ill_noreq_err", err_o, 1'b1);
    check("ill_noreq_gv",  grant_valid_o, 1'b0);
    check("ill_noreq_req", req_o, 4'b0110);
    gnt_i = 4'b1000; err_clr_i = 1'b1; step(); gnt_i = 4'b0000;
    check("ill_errwins", err_o, 1'b1);
    step(); err_clr_i = 1'b0;
    check("ill_clr2", err_o, 1'b0);

    // Asynchronous reset mid-stream with counts {2,1,0,3}
    reset = 1'b0; #2 reset = 1'b1;
    push_i = 4'b1011; step();
    push_i = 4'b1001; step();
    push_i = 4'b1000; step();
    push_i = 4'b0000;
    check("mid_req", req_o, 4'b1011);
    #3 reset = 1'b0;
    #1;
    check("mid_req_rst",  req_o, 4'b0000);
    check("mid_full_rst", full_o, 4'b0000);
    #2 reset = 1'b1;
    push_i = 4'b1000; step(); push_i = 4'b0000;
    check("mid_after", req_o, 4'b1000);

    // Random push/grant run against a per-port count scoreboard
    reset = 1'b0; #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_idx = 2'd0;
    rnd_bad_start = bad;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) m_req[i] = (m_cnt[i] != 0);
      r_push = 4'($urandom_range(0, 15));
      r_gnt  = ($urandom_range(0, 3) != 0) ? prio(m_req) : 4'b0000;
      push_i = r_push;
      gnt_i  = r_gnt;
      m_drop = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (r_gnt[i] && !r_push[i])       m_cnt[i]--;
        else if (r_push[i] && !r_gnt[i]) begin
          if (m_cnt[i] == 7) m_drop[i] = 1'b1;
          else               m_cnt[i]++;
        end
      end
      m_gv = (r_gnt != 4'b0000);
      for (int i = 0; i < 4; i++) if (r_gnt[i]) m_idx = 2'(i);
      step();
      for (int i = 0; i < 4; i++) begin
        m_req[i]  = (m_cnt[i] != 0);
        m_full[i] = (m_cnt[i] == 7);
      end
      check("rnd_req",  req_o, m_req);
      check("rnd_full", full_o, m_full);
      check("rnd_drop", drop_o, m_drop);
      check("rnd_gv",   grant_valid_o, m_gv);
      if (m_gv) check("rnd_idx", grant_idx_o, m_idx);
      check("rnd_err",  err_o, 1'b0);
      if (bad - rnd_bad_start > 20) break;
    end
    push_i = 4'b0000;
    gnt_i  = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
